main_mem_latency: RTL and testbench
===================================

# main_mem_latency

Block-organised main data memory sitting directly downstream of the cache, serving whole-block (128-bit) reads and write-backs. It holds 1 KiB as 64 blocks of 16 bytes, addressed by a 10-bit byte address. It models DRAM access latency with a request/done handshake and a configurable cycle count. The cache stalls on `busy` and consumes the block when `done` pulses.

## Interface
Parameters:
- `LATENCY`, 4 — cycles from request acceptance to `done`; legal range 1..255.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `req`  in  1  — request strobe, sampled only in IDLE.
- `read_write`  in  1  — 1 = write block, 0 = read block.
- `address`  in  10  — byte address; `address[9:4]` is the block index, `[3:0]` ignored.
- `write_data`  in  128  — block to write; word 0 in `[31:0]`.
- `read_data`  out  128  — last block read; word 0 in `[31:0]`.
- `done`  out  1  — one-cycle completion pulse.
- `busy`  out  1  — high whenever state is not IDLE.
- `rd_count`, `wr_count`  out  16  — present only with `MEM_STATS_EN`.

## Operation
- Storage: 64 × 128-bit array. On reset, word k (k = 0..255, block k/4, lane k%4) = 32'h0000_0000 + k.
- FSM states and transitions:
  - IDLE -> BUSY when `req` = 1. Latch `read_write`, `address[9:4]`, and `write_data`. Load counter with LATENCY-1.
  - BUSY, counter ≠ 0: decrement counter and stay in BUSY.
  - BUSY, counter = 0: perform the access and go to DONE. A read loads `read_data` from the latched block; a write stores the latched data into the array.
  - DONE -> IDLE unconditionally.
- Inputs are ignored outside IDLE, so changes to inputs after acceptance have no effect.
- `read_data` changes only when a read completes. It holds its value through writes and idle cycles.
- A write followed by a read of the same block returns the written data.

## Timing
- Reset values: state IDLE, `done` 0, `busy` 0, `read_data` 0, counter 0, counters 0. The array is re-initialised to the pattern above.
- Let acceptance be edge E0.
  - `done` is high for exactly one cycle after edge E(LATENCY).
  - The array or `read_data` updates at that same edge.
  - `busy` is high from after E0 through the DONE cycle.
- The earliest next acceptance is edge E(LATENCY+2). A `req` held high continuously produces back-to-back transactions spaced LATENCY+2 cycles apart.
- With LATENCY = 1, BUSY lasts one cycle.
- Reset mid-transaction aborts it: no array write, no `done`, and `read_data` returns to 0.
- `done` and `busy` are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MEM_STATS_EN` defined:
  - Adds `rd_count` and `wr_count`, which increment on each completed read or write (at the `done` edge).
  - Both saturate at 16'hFFFF and are cleared by reset.
  - An aborted transaction does not count.
- `MEM_STATS_EN` undefined: the ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset, then read `address` = 10'h020 with LATENCY = 4 -> `done` pulses exactly 4 cycles after acceptance. `read_data` = {32'h0B, 32'h0A, 32'h09, 32'h08}. `busy` stays high for 5 cycles.
- Write 128'hDEAD…BEEF to 10'h3F0, then read 10'h3FC -> the read returns 128'hDEAD…BEEF; block 62 is unchanged on a subsequent read.
- Hold `req` = 1 continuously with reads of 10'h000 and 10'h010 -> accepts occur 6 cycles apart. Input changes during BUSY are ignored.
- Assert `reset` two cycles into a write to block 5 -> no `done`, and `busy` drops immediately. Reading 10'h050 afterwards returns {32'h17, 32'h16, 32'h15, 32'h14}.
- LATENCY = 1: a read of 10'h000 -> `done` appears in the cycle after acceptance with {32'h3, 32'h2, 32'h1, 32'h0}.
- With `MEM_STATS_EN`: 3 reads, 2 writes, and 1 aborted read -> `rd_count` = 3, `wr_count` = 2.

Source files
------------

// File: rtl/main_mem_latency.sv
// rtl/main_mem_latency.sv - 64 x 128-bit block memory with a fixed-latency req/done handshake.
// Optional read/write completion counters are enabled by defining MEM_STATS_EN.
module main_mem_latency #(
  parameter int unsigned LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         read_write,
  input  logic [9:0]   address,
  input  logic [127:0] write_data,
  output logic [127:0] read_data,
  output logic         done,
  output logic         busy
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t       state;
  state_t       state_nxt;
  logic [7:0]   count;
  logic [7:0]   count_nxt;
  logic         accept;
  logic         access;

  logic         lat_rw;
  logic [5:0]   lat_blk;
  logic [127:0] lat_data;

  logic [127:0] mem [64];

  // Byte offset within a block is irrelevant for whole-block transfers.
  logic         unused_offset;
  assign unused_offset = ^address[3:0];

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = BUSY;
          count_nxt = LAT_M1;
          accept    = 1'b1;
        end
      end
      BUSY: begin
        if (count != 8'd0) begin
          count_nxt = count - 8'd1;
        end else begin
          access    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= 8'd0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      done  <= access;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Request fields are captured only at acceptance so later input changes cannot leak in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_rw   <= 1'b0;
      lat_blk  <= 6'd0;
      lat_data <= 128'd0;
    end else if (accept) begin
      lat_rw   <= read_write;
      lat_blk  <= address[9:4];
      lat_data <= write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= 128'd0;
    end else if (access && !lat_rw) begin
      read_data <= mem[lat_blk];
    end
  end

  // Reset reloads the array so word k holds k (lane 0 in the low 32 bits).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 64; b++) begin
        mem[b] <= {32'(4 * b + 3), 32'(4 * b + 2), 32'(4 * b + 1), 32'(4 * b)};
      end
    end else if (access && lat_rw) begin
      mem[lat_blk] <= lat_data;
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (access) begin
      if (lat_rw) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_main_mem_latency.sv
// tb/tb_main_mem_latency.sv - directed self-checking bench for main_mem_latency.
module tb_main_mem_latency;

  logic         clk = 1'b0;
  logic         reset;
  logic         req;
  logic         read_write;
  logic [9:0]   address;
  logic [127:0] write_data;
  logic [127:0] read_data;
  logic         done;
  logic         busy;

  logic         req_b;
  logic [9:0]   address_b;
  logic [127:0] read_data_b;
  logic         done_b;
  logic         busy_b;

`ifdef MEM_STATS_EN
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;
  logic [15:0]  rd_count_b;
  logic [15:0]  wr_count_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  main_mem_latency #(.LATENCY(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .read_write (read_write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .done       (done),
    .busy       (busy)
`ifdef MEM_STATS_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  main_mem_latency #(.LATENCY(1)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .req        (req_b),
    .read_write (1'b0),
    .address    (address_b),
    .write_data (128'd0),
    .read_data  (read_data_b),
    .done       (done_b),
    .busy       (busy_b)
`ifdef MEM_STATS_EN
    ,
    .rd_count   (rd_count_b),
    .wr_count   (wr_count_b)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one transaction, scrambling inputs while busy, and returns at the done cycle.
  task automatic txn(input logic rw, input logic [9:0] a, input logic [127:0] wd,
                     output int lat, output int bcnt);
    req        = 1'b1;
    read_write = rw;
    address    = a;
    write_data = wd;
    tick();
    req  = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 300) begin
      if (busy === 1'b1) bcnt++;
      read_write = 1'($urandom);
      address    = 10'($urandom);
      write_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      lat++;
    end
    if (busy === 1'b1) bcnt++;
  endtask

  int lat;
  int bcnt;
  int cyc;
  int d1;
  int d2;
  logic [127:0] rd1;
  logic [127:0] rd2;

  initial begin
    reset      = 1'b1;
    req        = 1'b0;
    read_write = 1'b0;
    address    = 10'd0;
    write_data = 128'd0;
    req_b      = 1'b0;
    address_b  = 10'd0;
    tick();
    tick();
    chk("reset_done", {127'd0, done}, 128'd0);
    chk("reset_busy", {127'd0, busy}, 128'd0);
    chk("reset_read_data", read_data, 128'd0);
    reset = 1'b0;
    tick();

    txn(1'b0, 10'h020, 128'd0, lat, bcnt);
    chk("read020_latency", 128'(lat), 128'd4);
    chk("read020_busy_cycles", 128'(bcnt), 128'd5);
    chk("read020_data", read_data, {32'h0B, 32'h0A, 32'h09, 32'h08});
    tick();
    chk("read020_done_cleared", {127'd0, done}, 128'd0);
    chk("read020_busy_cleared", {127'd0, busy}, 128'd0);

    txn(1'b1, 10'h3F0, 128'hDEAD0000_11112222_33334444_0000BEEF, lat, bcnt);
    chk("write3f0_latency", 128'(lat), 128'd4);
    chk("write_holds_read_data", read_data, {32'h0B, 32'h0A, 32'h09, 32'h08});
    tick();
    txn(1'b0, 10'h3FC, 128'd0, lat, bcnt);
    chk("read3fc_data", read_data, 128'hDEAD0000_11112222_33334444_0000BEEF);
    tick();
    txn(1'b0, 10'h3E0, 128'd0, lat, bcnt);
    chk("read3e0_unchanged", read_data, {32'hFB, 32'hFA, 32'hF9, 32'hF8});
    tick();

    // Back-to-back with req held high; inputs perturbed mid-transaction.
    req        = 1'b1;
    read_write = 1'b0;
    address    = 10'h000;
    tick();
    cyc = 0;
    d1  = -1;
    d2  = -1;
    rd1 = 128'd0;
    rd2 = 128'd0;
    while (d2 < 0 && cyc < 40) begin
      cyc++;
      if (cyc == 1) address = 10'h010;
      if (cyc == 7) begin
        read_write = 1'b1;
        address    = 10'h3F0;
        write_data = 128'h5555;
      end
      tick();
      if (done === 1'b1) begin
        if (d1 < 0) begin
          d1  = cyc;
          rd1 = read_data;
        end else begin
          d2  = cyc;
          rd2 = read_data;
        end
      end
    end
    req = 1'b0;
    chk("b2b_first_done", 128'(d1), 128'd4);
    chk("b2b_first_data", rd1, {32'h3, 32'h2, 32'h1, 32'h0});
    chk("b2b_second_done", 128'(d2), 128'd10);
    chk("b2b_second_data", rd2, {32'h7, 32'h6, 32'h5, 32'h4});
    tick();
    chk("b2b_idle_after", {127'd0, busy}, 128'd0);
    tick();
    chk("b2b_no_third", {127'd0, busy}, 128'd0);

    // Reset two cycles into a write of block 5.
    req        = 1'b1;
    read_write = 1'b1;
    address    = 10'h050;
    write_data = {4{32'hA5A5A5A5}};
    tick();
    req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("abort_busy_drop", {127'd0, busy}, 128'd0);
    chk("abort_no_done", {127'd0, done}, 128'd0);
    chk("abort_read_data", read_data, 128'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("abort_still_no_done", {127'd0, done}, 128'd0);
    txn(1'b0, 10'h050, 128'd0, lat, bcnt);
    chk("read050_data", read_data, {32'h17, 32'h16, 32'h15, 32'h14});
    tick();

    req_b     = 1'b1;
    address_b = 10'h000;
    tick();
    req_b = 1'b0;
    chk("lat1_busy", {127'd0, busy_b}, 128'd1);
    chk("lat1_not_done_yet", {127'd0, done_b}, 128'd0);
    tick();
    chk("lat1_done", {127'd0, done_b}, 128'd1);
    chk("lat1_data", read_data_b, {32'h3, 32'h2, 32'h1, 32'h0});
    tick();
    chk("lat1_done_cleared", {127'd0, done_b}, 128'd0);
    chk("lat1_busy_cleared", {127'd0, busy_b}, 128'd0);

`ifdef MEM_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("stats_reset_rd", 128'(rd_count), 128'd0);
    chk("stats_reset_wr", 128'(wr_count), 128'd0);
    txn(1'b0, 10'h100, 128'd0, lat, bcnt);
    tick();
    txn(1'b1, 10'h110, 128'h1, lat, bcnt);
    tick();
    txn(1'b0, 10'h110, 128'd0, lat, bcnt);
    tick();
    txn(1'b1, 10'h120, 128'h2, lat, bcnt);
    tick();
    txn(1'b0, 10'h120, 128'd0, lat, bcnt);
    tick();
    req        = 1'b1;
    read_write = 1'b0;
    address    = 10'h130;
    tick();
    req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    chk("stats_abort_rd", 128'(rd_count), 128'd0);
    txn(1'b0, 10'h100, 128'd0, lat, bcnt);
    tick();
    txn(1'b0, 10'h110, 128'd0, lat, bcnt);
    tick();
    txn(1'b1, 10'h120, 128'h3, lat, bcnt);
    tick();
    txn(1'b0, 10'h120, 128'd0, lat, bcnt);
    tick();
    txn(1'b1, 10'h130, 128'h4, lat, bcnt);
    tick();
    req        = 1'b1;
    read_write = 1'b0;
    address    = 10'h140;
    tick();
    req = 1'b0;
    tick();
    chk("stats_rd_count", 128'(rd_count), 128'd3);
    chk("stats_wr_count", 128'(wr_count), 128'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
